// File: rtl/kappa3_dbg_sequencer.sv
// kappa3_dbg_sequencer
//   Command/response debug host for kappa3_light_core. One command is taken
//   at a time. The block drives the core's dbg_* strobes and run with fixed
//   timing, then returns one response beat. DUMP returns NREGS+1 beats.
//
// Ports
//   clock, reset          sole clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_addr, cmd_data
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_err, rsp_last
//   busy                  high whenever the FSM is not idle
//   run / running         core run request and core run status
//   dbg_in, dbg_pc_ld, dbg_reg_ld, dbg_reg_addr, dbg_mem_addr,
//   dbg_mem_read, dbg_mem_write    core debug-port drive
//   dbg_pc_out, dbg_reg_out, dbg_mem_out   core read-back
//
// Build option
//   KAPPA3_DBG_SEQ_TIMEOUT_EN  RUN gives up once its cycle count reaches
//                              2^TO_W-1 and answers with rsp_err=1.
module kappa3_dbg_sequencer #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int RW         = 5,
    parameter int NREGS      = 32,
    parameter int STROBE_CYC = 1,
    parameter int SETTLE_CYC = 2,
    parameter int RUN_PULSE  = 2,
    parameter int TO_W       = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          rsp_last,
    output logic          busy,
    output logic          run,
    input  logic          running,
    output logic [DW-1:0] dbg_in,
    output logic          dbg_pc_ld,
    output logic          dbg_reg_ld,
    output logic [RW-1:0] dbg_reg_addr,
    output logic [AW-1:0] dbg_mem_addr,
    output logic          dbg_mem_read,
    output logic          dbg_mem_write,
    input  logic [DW-1:0] dbg_pc_out,
    input  logic [DW-1:0] dbg_reg_out,
    input  logic [DW-1:0] dbg_mem_out
);

    localparam logic [2:0] OP_WR_PC  = 3'd0;
    localparam logic [2:0] OP_WR_MEM = 3'd1;
    localparam logic [2:0] OP_RD_MEM = 3'd2;
    localparam logic [2:0] OP_WR_REG = 3'd3;
    localparam logic [2:0] OP_RD_REG = 3'd4;
    localparam logic [2:0] OP_RUN    = 3'd5;
    localparam logic [2:0] OP_DUMP   = 3'd6;

    localparam int BW = $clog2(NREGS + 1);

`ifdef KAPPA3_DBG_SEQ_TIMEOUT_EN
    localparam logic [DW-1:0] TO_MAX = DW'((64'd1 << TO_W) - 64'd1);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_STROBE, S_SETTLE, S_RESP,
        S_RUN_P, S_RUN_W, S_DUMP_S, S_DUMP_R
    } state_t;

    state_t        state;
    logic [2:0]    op;
    logic [15:0]   tcnt;      // phase timer for strobe/settle/run pulse
    logic [DW-1:0] cnt;       // RUN cycle counter, saturating
    logic          low_seen;  // running was low on the previous RUN_W cycle
    logic [BW-1:0] beat;      // DUMP beat index, 0 = PC
    logic [DW-1:0] cnt_inc;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            op            <= '0;
            tcnt          <= '0;
            cnt           <= '0;
            low_seen      <= 1'b0;
            beat          <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            rsp_last      <= 1'b0;
            run           <= 1'b0;
            dbg_in        <= '0;
            dbg_pc_ld     <= 1'b0;
            dbg_reg_ld    <= 1'b0;
            dbg_reg_addr  <= '0;
            dbg_mem_addr  <= '0;
            dbg_mem_read  <= 1'b0;
            dbg_mem_write <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready rises one cycle after reset release
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        op           <= cmd_op;
                        dbg_in       <= cmd_data;
                        dbg_mem_addr <= cmd_addr;
                        dbg_reg_addr <= cmd_addr[RW-1:0];
                        tcnt         <= '0;
                        case (cmd_op)
                            OP_RUN: begin
                                run      <= 1'b1;
                                cnt      <= '0;
                                low_seen <= 1'b0;
                                state    <= S_RUN_P;
                            end
                            OP_DUMP: begin
                                beat         <= '0;
                                dbg_reg_addr <= '0;
                                state        <= S_DUMP_S;
                            end
                            3'd7: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_last  <= 1'b1;
                                rsp_data  <= '0;
                                state     <= S_RESP;
                            end
                            default: state <= S_SETUP;
                        endcase
                    end
                end

                S_SETUP: begin
                    // RD_REG has no strobe; the register port is combinational
                    dbg_pc_ld     <= (op == OP_WR_PC);
                    dbg_mem_write <= (op == OP_WR_MEM);
                    dbg_mem_read  <= (op == OP_RD_MEM);
                    dbg_reg_ld    <= (op == OP_WR_REG);
                    tcnt          <= '0;
                    state         <= S_STROBE;
                end

                S_STROBE: begin
                    if (tcnt == 16'(STROBE_CYC - 1)) begin
                        dbg_pc_ld     <= 1'b0;
                        dbg_mem_write <= 1'b0;
                        dbg_mem_read  <= 1'b0;
                        dbg_reg_ld    <= 1'b0;
                        tcnt          <= '0;
                        state         <= S_SETTLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (tcnt == 16'(SETTLE_CYC - 1)) begin
                        if (op == OP_RD_MEM)      rsp_data <= dbg_mem_out;
                        else if (op == OP_RD_REG) rsp_data <= dbg_reg_out;
                        else                      rsp_data <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_last  <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_last  <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_RUN_P: begin
                    cnt <= cnt_inc;
                    if (tcnt == 16'(RUN_PULSE - 1)) begin
                        run   <= 1'b0;
                        state <= S_RUN_W;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_RUN_W: begin
                    low_seen <= ~running;
                    // count reported includes the completing cycle
                    if (!running && low_seen) begin
                        rsp_data  <= cnt_inc;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_last  <= 1'b1;
                        state     <= S_RESP;
                    end
`ifdef KAPPA3_DBG_SEQ_TIMEOUT_EN
                    else if (cnt >= TO_MAX) begin
                        rsp_data  <= TO_MAX;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        state     <= S_RESP;
                    end
`endif
                    else begin
                        cnt <= cnt_inc;
                    end
                end

                S_DUMP_S: begin
                    if (tcnt == 16'(SETTLE_CYC - 1)) begin
                        rsp_data  <= (beat == '0) ? dbg_pc_out : dbg_reg_out;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_last  <= (beat == BW'(NREGS));
                        tcnt      <= '0;
                        state     <= S_DUMP_R;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_DUMP_R: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            // beat k reads x(k-1): the new address is the old index
                            beat         <= beat + 1'b1;
                            dbg_reg_addr <= RW'(beat);
                            state        <= S_DUMP_S;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kappa3_dbg_sequencer.sv
module tb_kappa3_dbg_sequencer;

`ifdef KAPPA3_DBG_SEQ_TIMEOUT_EN
    localparam int TB_TO_W = 8;
`else
    localparam int TB_TO_W = 20;
`endif
    localparam int SC  = 1;
    localparam int ST  = 2;
    localparam int RP  = 2;
    localparam int NR  = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_last, busy, run;
    logic [31:0] rsp_data, dbg_in, dbg_mem_addr, dbg_pc_out, dbg_reg_out, dbg_mem_out;
    logic        running = 1'b0;
    logic        dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write;
    logic [4:0]  dbg_reg_addr;

    kappa3_dbg_sequencer #(.TO_W(TB_TO_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
        .run(run), .running(running),
        .dbg_in(dbg_in), .dbg_pc_ld(dbg_pc_ld), .dbg_reg_ld(dbg_reg_ld),
        .dbg_reg_addr(dbg_reg_addr), .dbg_mem_addr(dbg_mem_addr),
        .dbg_mem_read(dbg_mem_read), .dbg_mem_write(dbg_mem_write),
        .dbg_pc_out(dbg_pc_out), .dbg_reg_out(dbg_reg_out), .dbg_mem_out(dbg_mem_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- core model ----------------
    logic [31:0] c_pc = '0;
    logic [31:0] c_regs [32] = '{default: 32'd0};
    logic [31:0] c_mem  [32] = '{default: 32'd0};
    logic [31:0] c_memout = '0;
    logic        started = 1'b0, stuck = 1'b0;
    int          rrem = 0, run_len = 10;

    always @(posedge clock) begin
        if (dbg_pc_ld) c_pc <= dbg_in;
        if (dbg_reg_ld) c_regs[dbg_reg_addr] <= dbg_in;
        if (dbg_mem_write) c_mem[dbg_mem_addr[6:2]] <= dbg_in;
        if (dbg_mem_read) c_memout <= c_mem[dbg_mem_addr[6:2]];
    end
    assign dbg_pc_out  = c_pc;
    assign dbg_reg_out = (dbg_reg_addr == 5'd0) ? 32'd0 : c_regs[dbg_reg_addr];
    assign dbg_mem_out = c_memout;

    // running rises the cycle after run, stays high run_len cycles
    always @(posedge clock) begin
        if (run && !started) begin
            started <= 1'b1; running <= 1'b1; rrem <= run_len;
        end else if (running && !stuck) begin
            if (rrem == 1) running <= 1'b0;
            rrem <= rrem - 1;
        end
        if (!run && !running) started <= 1'b0;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        err, last;
        int          ecyc;    // expected first rsp_valid cycle, -1 = unchecked
        int          strb, runc;
        logic        chk_cnt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_regs [32] = '{default: 32'd0};
    logic [31:0] m_mem  [32] = '{default: 32'd0};
    int  n_cmp = 0, n_bad = 0, n_strb = 0, n_run = 0;
    logic exp_timeout = 1'b0, hold_low = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic e, input logic l,
                        input int ec, input int s, input int r, input logic c);
        exp_t x;
        x.data = d; x.err = e; x.last = l; x.ecyc = ec; x.strb = s; x.runc = r; x.chk_cnt = c;
        sbq.push_back(x);
    endtask

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        int w, t, lat, rc;
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        w = 0;
        do begin @(negedge clock); w++; end while (!cmd_ready && w < 3000);
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            finish_up();
        end
        t = cyc; n_strb = 0; n_run = 0;
        lat = t + 2 + SC + ST;
        case (op)
            3'd0: begin m_pc = data; push(0, 0, 1, lat, SC, 0, 1); end
            3'd1: begin m_mem[addr[6:2]] = data; push(0, 0, 1, lat, SC, 0, 1); end
            3'd2: push(m_mem[addr[6:2]], 0, 1, lat, SC, 0, 1);
            3'd3: begin
                if (addr[4:0] != 0) m_regs[addr[4:0]] = data;
                push(0, 0, 1, lat, SC, 0, 1);
            end
            3'd4: push(m_regs[addr[4:0]], 0, 1, lat, 0, 0, 1);
            3'd5: begin
                // response after running has been seen low on two cycles in the wait phase
                rc = ((run_len + 1 > RP) ? run_len + 1 : RP) + 2;
                if (exp_timeout) push(32'((64'd1 << TB_TO_W) - 1), 1, 1, -1, 0, RP, 1);
                else             push(32'(rc), 0, 1, -1, 0, RP, 1);
            end
            3'd6: for (int k = 0; k <= NR; k++)
                push((k == 0) ? m_pc : m_regs[k-1], 0, k == NR, -1, 0, 0, k == NR);
            default: push(0, 1, 1, t + 1, 0, 0, 1);
        endcase
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sbq.size() != 0 || !cmd_ready) && w < 5000) begin @(negedge clock); w++; end
        chk("drain_in_time", w < 5000, 1);
    endtask

    // response back-pressure
    initial forever begin
        @(posedge clock); #1;
        rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // monitor: strobes/run activity and response beats
    int          first_cyc = 0;
    logic [31:0] first_data = '0;
    logic        in_beat = 1'b0;
    initial forever begin
        exp_t e;
        int ns;
        @(negedge clock);
        ns = int'(dbg_pc_ld) + int'(dbg_reg_ld) + int'(dbg_mem_read) + int'(dbg_mem_write);
        if (ns != 0) begin n_strb++; chk("strobe_onehot", ns, 1); end
        if (run) n_run++;
        if (!rsp_valid) in_beat = 1'b0;
        else begin
            if (!in_beat) begin in_beat = 1'b1; first_cyc = cyc; first_data = rsp_data; end
            if (rsp_ready) begin
                in_beat = 1'b0;
                if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_last", rsp_last, e.last);
                    chk("rsp_stable", rsp_data, first_data);
                    if (e.ecyc >= 0) chk("rsp_latency", first_cyc, e.ecyc);
                    if (e.chk_cnt) begin
                        chk("strobe_cycles", n_strb, e.strb);
                        chk("run_cycles", n_run, e.runc);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int w;
        // reset values
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err_last", {rsp_err, rsp_last}, 0);
        chk("rst_run", run, 0);
        chk("rst_strobes", {dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write}, 0);
        chk("rst_dbg_in", dbg_in, 0);
        chk("rst_addrs", {dbg_mem_addr, 27'd0, dbg_reg_addr}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_release_ready", cmd_ready, 1);

        // reset in the middle of a WR_MEM strobe
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 32'h1000_007C; cmd_data = 32'hA5A5_A5A5;
        w = 0;
        do begin @(negedge clock); w++; end while (!cmd_ready && w < 100);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        w = 0;
        while (!dbg_mem_write && w < 20) begin @(negedge clock); w++; end
        chk("abort_strobe_seen", dbg_mem_write, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_strobe_drop", dbg_mem_write, 0);
        chk("abort_busy", busy, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ready", cmd_ready, 1);
        repeat (6) @(negedge clock);
        chk("abort_no_rsp", rsp_valid, 0);

        // directed cases
        send(3'd0, 32'h1000_0000, 32'h1000_0000);
        send(3'd6, 32'h0, 32'h0);
        send(3'd1, 32'h1000_0004, 32'hDEAD_BEEF);
        send(3'd2, 32'h1000_0004, 32'h0);
        send(3'd3, 32'd5, 32'h1234_5678);
        drain();
        hold_low = 1'b1;
        send(3'd4, 32'd5, 32'h0);
        repeat (14) @(negedge clock);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, 32'h1234_5678);
        hold_low = 1'b0;
        send(3'd3, 32'd0, 32'hFFFF_FFFF);
        send(3'd4, 32'd0, 32'h0);
        run_len = 99;
        send(3'd5, 32'h0, 32'h0);
        send(3'd7, 32'h0, 32'h0);
        drain();

`ifdef KAPPA3_DBG_SEQ_TIMEOUT_EN
        stuck = 1'b1; run_len = 5; exp_timeout = 1'b1;
        send(3'd5, 32'h0, 32'h0);
        drain();
        stuck = 1'b0; exp_timeout = 1'b0;
        repeat (20) @(negedge clock);
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd3 || op == 3'd4) a = 32'($urandom_range(0, 31));
            else                          a = 32'h1000_0000 + 32'($urandom_range(0, 30) * 4);
            if (op == 3'd5) run_len = $urandom_range(5, 40);
            send(op, a, $urandom);
        end
        drain();
        finish_up();
    end

endmodule
